// File: rtl/frame_rx.sv
// Length-prefixed frame receiver: checks the XOR checksum, buffers one good
// frame and replays its payload on a valid/ready stream with status/counters.
module frame_rx #(
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rxd,
  input  logic             rx_dv,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic [7:0]       out_len,
  output logic             frame_ok,
  output logic             frame_err,
  output logic [2:0]       err_code,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int unsigned PTR_W = $clog2(MAX_LEN);

  localparam logic [2:0] RX_IDLE    = 3'd0;
  localparam logic [2:0] RX_PAYLOAD = 3'd1;
  localparam logic [2:0] RX_CHK     = 3'd2;
  localparam logic [2:0] RX_END     = 3'd3;
  localparam logic [2:0] RX_DROP    = 3'd4;

  localparam logic [0:0] DR_IDLE = 1'b0;
  localparam logic [0:0] DR_BUSY = 1'b1;

  localparam logic [2:0] E_LEN   = 3'd1;
  localparam logic [2:0] E_SHORT = 3'd2;
  localparam logic [2:0] E_CSUM  = 3'd3;
  localparam logic [2:0] E_LONG  = 3'd4;
  localparam logic [2:0] E_OVF   = 3'd5;

  logic [7:0] mem [MAX_LEN];

  logic [2:0] rx_state, rx_state_d;
  logic [7:0] len_q, len_d;
  logic [7:0] csum_q, csum_d;
  logic [7:0] wr_ptr_q, wr_ptr_d;
  logic       match_q, match_d;
  logic       wr_en;
  logic       ok_d, err_d;
  logic [2:0] code_d;

  logic [0:0] dr_state, dr_state_d;
  logic [7:0] rd_ptr_q, rd_ptr_d;
  logic [7:0] out_data_d;
  logic       out_valid_d;
  logic       out_last_d;
  logic [7:0] out_len_d;
  logic       xfer;

  logic [CNT_W-1:0] frame_cnt_d, err_cnt_d;

  // Receive parser: next state, checksum accumulation and status decision.
  always_comb begin
    rx_state_d = rx_state;
    len_d      = len_q;
    csum_d     = csum_q;
    wr_ptr_d   = wr_ptr_q;
    match_d    = match_q;
    wr_en      = 1'b0;
    ok_d       = 1'b0;
    err_d      = 1'b0;
    code_d     = 3'd0;
    case (rx_state)
      RX_IDLE: begin
        if (rx_dv) begin
          len_d    = rxd;
          csum_d   = rxd;
          wr_ptr_d = 8'd0;
          if (rxd == 8'd0 || 32'(rxd) > MAX_LEN) begin
            err_d      = 1'b1;
            code_d     = E_LEN;
            rx_state_d = RX_DROP;
          end else if (dr_state == DR_BUSY) begin
            err_d      = 1'b1;
            code_d     = E_OVF;
            rx_state_d = RX_DROP;
          end else begin
            rx_state_d = RX_PAYLOAD;
          end
        end
      end
      RX_PAYLOAD: begin
        if (rx_dv) begin
          wr_en    = 1'b1;
          csum_d   = csum_q ^ rxd;
          wr_ptr_d = wr_ptr_q + 8'd1;
          if (wr_ptr_q == len_q - 8'd1) rx_state_d = RX_CHK;
        end else begin
          err_d      = 1'b1;
          code_d     = E_SHORT;
          rx_state_d = RX_IDLE;
        end
      end
      RX_CHK: begin
        if (rx_dv) begin
          match_d    = (rxd == csum_q);
          rx_state_d = RX_END;
        end else begin
          err_d      = 1'b1;
          code_d     = E_SHORT;
          rx_state_d = RX_IDLE;
        end
      end
      RX_END: begin
        if (rx_dv) begin
          err_d      = 1'b1;
          code_d     = E_LONG;
          rx_state_d = RX_DROP;
        end else begin
          if (match_q) begin
            ok_d = 1'b1;
          end else begin
            err_d  = 1'b1;
            code_d = E_CSUM;
          end
          rx_state_d = RX_IDLE;
        end
      end
      RX_DROP: begin
        if (!rx_dv) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  assign xfer = out_valid & out_ready;

  // Drain sequencer: prefetches the next byte so the stream sustains 1 byte/cycle.
  always_comb begin
    dr_state_d  = dr_state;
    rd_ptr_d    = rd_ptr_q;
    out_data_d  = out_data;
    out_valid_d = out_valid;
    out_last_d  = out_last;
    out_len_d   = out_len;
    case (dr_state)
      DR_IDLE: begin
        if (ok_d) begin
          dr_state_d  = DR_BUSY;
          rd_ptr_d    = 8'd0;
          out_valid_d = 1'b1;
          out_len_d   = len_q;
          out_data_d  = mem[PTR_W'(0)];
          out_last_d  = (len_q == 8'd1);
        end
      end
      DR_BUSY: begin
        if (xfer) begin
          if (out_last) begin
            dr_state_d  = DR_IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
          end else begin
            rd_ptr_d   = rd_ptr_q + 8'd1;
            out_data_d = mem[PTR_W'(rd_ptr_q + 8'd1)];
            out_last_d = (rd_ptr_q + 8'd2 == out_len);
          end
        end
      end
      default: dr_state_d = DR_IDLE;
    endcase
  end

  // Saturating counters step together with their status pulse.
  always_comb begin
    frame_cnt_d = frame_cnt;
    err_cnt_d   = err_cnt;
    if (ok_d && frame_cnt != '1) frame_cnt_d = frame_cnt + CNT_W'(1);
    if (err_d && err_cnt != '1) err_cnt_d = err_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state  <= RX_IDLE;
      len_q     <= 8'd0;
      csum_q    <= 8'd0;
      wr_ptr_q  <= 8'd0;
      match_q   <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= 3'd0;
      dr_state  <= DR_IDLE;
      rd_ptr_q  <= 8'd0;
      out_data  <= 8'd0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_len   <= 8'd0;
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      rx_state  <= rx_state_d;
      len_q     <= len_d;
      csum_q    <= csum_d;
      wr_ptr_q  <= wr_ptr_d;
      match_q   <= match_d;
      frame_ok  <= ok_d;
      frame_err <= err_d;
      err_code  <= code_d;
      dr_state  <= dr_state_d;
      rd_ptr_q  <= rd_ptr_d;
      out_data  <= out_data_d;
      out_valid <= out_valid_d;
      out_last  <= out_last_d;
      out_len   <= out_len_d;
      frame_cnt <= frame_cnt_d;
      err_cnt   <= err_cnt_d;
    end
  end

  // Payload buffer; writes only happen in PAYLOAD, which is never entered while draining.
  always_ff @(posedge clk) begin
    if (wr_en) mem[PTR_W'(wr_ptr_q)] <= rxd;
  end

endmodule

// File: tb/tb_frame_rx.sv
// Randomised self-checking bench for frame_rx against a frame-level reference model.
module tb_frame_rx;
  localparam int unsigned MAX_LEN = 16;
  localparam int unsigned CNT_W   = 4;
  localparam int CMAX = (1 << CNT_W) - 1;

  typedef logic [7:0] bytes_t [$];

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [7:0] rxd = 8'd0;
  logic rx_dv = 1'b0;
  logic [7:0] out_data;
  logic out_valid;
  logic out_ready = 1'b0;
  logic out_last;
  logic [7:0] out_len;
  logic frame_ok, frame_err;
  logic [2:0] err_code;
  logic [CNT_W-1:0] frame_cnt, err_cnt;

  always #5 clk = ~clk;

  frame_rx #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .rxd(rxd), .rx_dv(rx_dv),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .out_len(out_len), .frame_ok(frame_ok),
    .frame_err(frame_err), .err_code(err_code),
    .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );

  int n_chk = 0, n_err = 0;
  int cyc = 0, viol = 0, vld_cnt = 0, pending = 0;
  int ok_seen, err_seen, pulse_tick, tick_idx, ok_cyc;
  logic [2:0] last_code;
  bit rdy_rand = 1'b0;
  logic [16:0] exp_q[$], got_q[$];
  int got_cyc[$];
  int exp_fcnt = 0, exp_ecnt = 0;

  // One clock: records transfers, pulses and stall-stability violations.
  task automatic tick();
    logic xfer, pv, plast, r;
    logic [7:0] pd, pl;
    if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
    r = rst;
    xfer = out_valid && out_ready && !rst;
    pv = out_valid; pd = out_data; plast = out_last; pl = out_len;
    @(posedge clk); #1;
    cyc++;
    if (xfer) begin
      got_q.push_back({plast, pl, pd});
      got_cyc.push_back(cyc);
      pending--;
    end
    if (!r && pv && !xfer && (!out_valid || out_data !== pd || out_last !== plast || out_len !== pl)) viol++;
    if (frame_ok && frame_err) viol++;
    if (out_valid) vld_cnt++;
    if (frame_ok) begin ok_seen++; pulse_tick = tick_idx; ok_cyc = cyc; end
    if (frame_err) begin err_seen++; last_code = err_code; pulse_tick = tick_idx; end
    tick_idx++;
  endtask

  // Frame-level rules: what the receiver must decide for a whole rx_dv burst.
  function automatic logic [2:0] classify(input bytes_t f, input bit busy);
    int l;
    logic [7:0] x;
    l = int'(f[0]);
    if (l == 0 || l > int'(MAX_LEN)) return 3'd1;
    if (busy) return 3'd5;
    if (f.size() < l + 2) return 3'd2;
    if (f.size() > l + 2) return 3'd4;
    x = 8'd0;
    for (int i = 0; i <= l; i++) x ^= f[i];
    return (x == f[l+1]) ? 3'd0 : 3'd3;
  endfunction

  function automatic bytes_t good_frame(input int l);
    bytes_t f;
    logic [7:0] x, b;
    f.push_back(8'(l));
    x = 8'(l);
    for (int i = 0; i < l; i++) begin
      b = 8'($urandom);
      f.push_back(b);
      x ^= b;
    end
    f.push_back(x);
    return f;
  endfunction

  task automatic send_frame(input bytes_t f, input int gap, output logic [2:0] code, output int et);
    int l;
    l = int'(f[0]);
    code = classify(f, pending > 0);
    case (code)
      3'd1, 3'd5: et = 0;
      3'd4:       et = l + 2;
      default:    et = f.size();
    endcase
    ok_seen = 0; err_seen = 0; pulse_tick = -1; tick_idx = 0; last_code = 3'd0;
    foreach (f[i]) begin
      rx_dv = 1'b1;
      rxd = f[i];
      tick();
    end
    rx_dv = 1'b0;
    rxd = 8'($urandom);
    repeat (gap) tick();
    if (code == 3'd0) begin
      for (int i = 0; i < l; i++) exp_q.push_back({(i == l - 1), 8'(l), f[i+1]});
      pending += l;
      if (exp_fcnt < CMAX) exp_fcnt++;
    end else if (exp_ecnt < CMAX) exp_ecnt++;
  endtask

  task automatic drain_wait();
    out_ready = 1'b1;
    for (int i = 0; i < 300 && pending > 0; i++) tick();
    repeat (2) tick();
  endtask

  task automatic model_reset();
    exp_q.delete(); got_q.delete(); got_cyc.delete();
    pending = 0; exp_fcnt = 0; exp_ecnt = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_dv = 1'b0; out_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    n_chk++;
    if ({out_data, out_valid, out_last, out_len, frame_ok, frame_err, err_code, frame_cnt, err_cnt} !== '0) begin
      n_err++;
      $display("FAIL reset: outputs=%h required all zero", {out_data, out_valid, out_last, out_len, frame_ok, frame_err, err_code, frame_cnt, err_cnt});
    end
    model_reset();
  endtask

  task automatic test_good();
    bytes_t f;
    logic [2:0] code;
    int et, bad;
    f = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    out_ready = 1'b1;
    send_frame(f, 1, code, et);
    n_chk++;
    if (ok_seen != 1 || err_seen != 0 || pulse_tick != et) begin
      n_err++;
      $display("FAIL good_status: ok=%0d err=%0d tick=%0d required ok=1 err=0 tick=%0d", ok_seen, err_seen, pulse_tick, et);
    end
    drain_wait();
    bad = 0;
    for (int i = 0; i < got_cyc.size(); i++) if (got_cyc[i] != ok_cyc + 1 + i) bad++;
    n_chk++;
    if (bad != 0 || got_cyc.size() != 3) begin
      n_err++;
      $display("FAIL good_timing: %0d transfers, %0d off-cycle, required 3 consecutive from cycle %0d", got_cyc.size(), bad, ok_cyc + 1);
    end
    bad = 0;
    foreach (exp_q[i]) if (i >= got_q.size() || got_q[i] !== exp_q[i]) bad++;
    n_chk++;
    if (bad != 0 || got_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL good_drain: got %0d bytes (%0d wrong), required %0d", got_q.size(), bad, exp_q.size());
    end
    n_chk++;
    if (frame_cnt !== CNT_W'(exp_fcnt)) begin
      n_err++;
      $display("FAIL good_cnt: frame_cnt=%0d required %0d", frame_cnt, exp_fcnt);
    end
    exp_q.delete(); got_q.delete(); got_cyc.delete();
  endtask

  task automatic test_backpressure();
    bytes_t f;
    logic [2:0] code;
    int et, bad;
    logic pat [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    f = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    out_ready = 1'b0;
    viol = 0;
    send_frame(f, 1, code, et);
    n_chk++;
    if (ok_seen != 1 || err_seen != 0 || pulse_tick != et) begin
      n_err++;
      $display("FAIL bp_status: ok=%0d err=%0d tick=%0d required ok=1 tick=%0d", ok_seen, err_seen, pulse_tick, et);
    end
    foreach (pat[i]) begin
      out_ready = pat[i];
      tick();
    end
    out_ready = 1'b0;
    repeat (2) tick();
    bad = 0;
    foreach (exp_q[i]) if (i >= got_q.size() || got_q[i] !== exp_q[i]) bad++;
    n_chk++;
    if (bad != 0 || got_q.size() != 3 || viol != 0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL bp_drain: got %0d bytes (%0d wrong) viol=%0d valid=%b, required 3 bytes viol=0 valid=0", got_q.size(), bad, viol, out_valid);
    end
    exp_q.delete(); got_q.delete(); got_cyc.delete();
    pending = 0;
  endtask

  task automatic test_errors();
    bytes_t tbl [4];
    logic [2:0] code;
    int et, v0;
    tbl[0] = '{8'h00};
    tbl[1] = '{8'h03, 8'h11};
    tbl[2] = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h04};
    tbl[3] = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h03, 8'hFF};
    out_ready = 1'b1;
    v0 = vld_cnt;
    foreach (tbl[k]) begin
      send_frame(tbl[k], 2, code, et);
      n_chk++;
      if (err_seen != 1 || ok_seen != 0 || last_code !== code || pulse_tick != et) begin
        n_err++;
        $display("FAIL err_%0d: ok=%0d err=%0d code=%0d tick=%0d required err=1 code=%0d tick=%0d", k, ok_seen, err_seen, last_code, pulse_tick, code, et);
      end
    end
    n_chk++;
    if (err_cnt !== CNT_W'(exp_ecnt) || vld_cnt != v0 || got_q.size() != 0) begin
      n_err++;
      $display("FAIL err_summary: err_cnt=%0d valid_cycles=%0d transfers=%0d required %0d 0 0", err_cnt, vld_cnt - v0, got_q.size(), exp_ecnt);
    end
  endtask

  task automatic test_overflow();
    bytes_t f;
    logic [2:0] code;
    int et, bad;
    out_ready = 1'b0;
    f = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    send_frame(f, 1, code, et);
    f = '{8'h01, 8'hAA, 8'hAB};
    send_frame(f, 2, code, et);
    n_chk++;
    if (err_seen != 1 || ok_seen != 0 || last_code !== code || pulse_tick != et) begin
      n_err++;
      $display("FAIL ovf_status: ok=%0d err=%0d code=%0d tick=%0d required code=%0d tick=%0d", ok_seen, err_seen, last_code, pulse_tick, code, et);
    end
    drain_wait();
    bad = 0;
    foreach (exp_q[i]) if (i >= got_q.size() || got_q[i] !== exp_q[i]) bad++;
    n_chk++;
    if (bad != 0 || got_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL ovf_drain: got %0d bytes (%0d wrong) required %0d", got_q.size(), bad, exp_q.size());
    end
    exp_q.delete(); got_q.delete(); got_cyc.delete();
  endtask

  task automatic test_boundary();
    bytes_t tbl [2];
    logic [2:0] code;
    int et, bad;
    tbl[0] = good_frame(int'(MAX_LEN));
    tbl[1] = good_frame(int'(MAX_LEN) + 1);
    out_ready = 1'b1;
    foreach (tbl[k]) begin
      send_frame(tbl[k], 1, code, et);
      n_chk++;
      if (ok_seen + err_seen != 1 || pulse_tick != et || (code == 3'd0 ? ok_seen != 1 : last_code !== code)) begin
        n_err++;
        $display("FAIL bound_%0d: ok=%0d err=%0d code=%0d tick=%0d required code=%0d tick=%0d", k, ok_seen, err_seen, last_code, pulse_tick, code, et);
      end
      drain_wait();
    end
    bad = 0;
    foreach (exp_q[i]) if (i >= got_q.size() || got_q[i] !== exp_q[i]) bad++;
    n_chk++;
    if (bad != 0 || got_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL bound_drain: got %0d bytes (%0d wrong) required %0d", got_q.size(), bad, exp_q.size());
    end
    exp_q.delete(); got_q.delete(); got_cyc.delete();
  endtask

  task automatic test_back_to_back();
    bytes_t tbl [3];
    logic [2:0] code;
    int et, bad;
    tbl[0] = '{8'h00};
    tbl[1] = good_frame(4);
    tbl[2] = good_frame(2);
    out_ready = 1'b1;
    foreach (tbl[k]) begin
      send_frame(tbl[k], 1, code, et);
      n_chk++;
      if (ok_seen + err_seen != 1 || pulse_tick != et || (code == 3'd0 ? ok_seen != 1 : last_code !== code)) begin
        n_err++;
        $display("FAIL b2b_%0d: ok=%0d err=%0d code=%0d tick=%0d required code=%0d tick=%0d", k, ok_seen, err_seen, last_code, pulse_tick, code, et);
      end
    end
    drain_wait();
    bad = 0;
    foreach (exp_q[i]) if (i >= got_q.size() || got_q[i] !== exp_q[i]) bad++;
    n_chk++;
    if (bad != 0 || got_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL b2b_drain: got %0d bytes (%0d wrong) required %0d", got_q.size(), bad, exp_q.size());
    end
    exp_q.delete(); got_q.delete(); got_cyc.delete();
  endtask

  task automatic test_saturate();
    logic [2:0] code;
    int et;
    out_ready = 1'b1;
    for (int k = 0; k <= CMAX; k++) begin
      send_frame(good_frame(int'($urandom_range(1, 3))), 1, code, et);
      drain_wait();
      n_chk++;
      if (ok_seen != 1 || frame_cnt !== CNT_W'(exp_fcnt)) begin
        n_err++;
        $display("FAIL sat_%0d: ok=%0d frame_cnt=%0d required ok=1 frame_cnt=%0d", k, ok_seen, frame_cnt, exp_fcnt);
      end
    end
    exp_q.delete(); got_q.delete(); got_cyc.delete();
  endtask

  task automatic test_reset_mid();
    bytes_t f;
    logic [2:0] code;
    int et, bad;
    out_ready = 1'b1;
    f = '{8'h05, 8'h01, 8'h02};
    foreach (f[i]) begin rx_dv = 1'b1; rxd = f[i]; tick(); end
    rst = 1'b1; rx_dv = 1'b0;
    tick();
    rst = 1'b0;
    n_chk++;
    if ({out_valid, frame_ok, frame_err, err_code, frame_cnt, err_cnt, out_data, out_last, out_len} !== '0) begin
      n_err++;
      $display("FAIL rst_frame: outputs=%h required all zero", {out_valid, frame_ok, frame_err, err_code, frame_cnt, err_cnt, out_data, out_last, out_len});
    end
    model_reset();
    out_ready = 1'b0;
    send_frame(good_frame(5), 1, code, et);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    rst = 1'b1;
    ok_seen = 0; err_seen = 0;
    tick();
    rst = 1'b0;
    n_chk++;
    if ({out_valid, frame_ok, frame_err, err_code, frame_cnt, err_cnt, out_data, out_last, out_len} !== '0 || ok_seen + err_seen != 0) begin
      n_err++;
      $display("FAIL rst_drain: outputs=%h pulses=%0d required all zero", {out_valid, frame_ok, frame_err, err_code, frame_cnt, err_cnt, out_data, out_last, out_len}, ok_seen + err_seen);
    end
    model_reset();
    out_ready = 1'b1;
    send_frame(good_frame(6), 1, code, et);
    drain_wait();
    bad = 0;
    foreach (exp_q[i]) if (i >= got_q.size() || got_q[i] !== exp_q[i]) bad++;
    n_chk++;
    if (ok_seen != 1 || pulse_tick != et || bad != 0 || got_q.size() != exp_q.size() || frame_cnt !== CNT_W'(1)) begin
      n_err++;
      $display("FAIL rst_fresh: ok=%0d bytes=%0d wrong=%0d frame_cnt=%0d required ok=1 bytes=%0d wrong=0 cnt=1", ok_seen, got_q.size(), bad, frame_cnt, exp_q.size());
    end
    exp_q.delete(); got_q.delete(); got_cyc.delete();
  endtask

  task automatic test_random();
    bytes_t f;
    logic [2:0] code;
    int et, bad, l, kind;
    viol = 0;
    rdy_rand = 1'b1;
    for (int k = 0; k < 40; k++) begin
      kind = int'($urandom_range(0, 5));
      l = int'($urandom_range(1, MAX_LEN));
      f = good_frame(l);
      case (kind)
        2: f[l+1] = f[l+1] ^ 8'($urandom_range(1, 255));
        3: f = f[0:int'($urandom_range(1, l + 1)) - 1];
        4: repeat ($urandom_range(1, 3)) f.push_back(8'($urandom));
        5: f[0] = ($urandom_range(0, 1) != 0) ? 8'd0 : 8'($urandom_range(MAX_LEN + 1, 255));
        default: ;
      endcase
      send_frame(f, int'($urandom_range(1, 3)), code, et);
      n_chk++;
      if (ok_seen + err_seen != 1 || pulse_tick != et || (code == 3'd0 ? ok_seen != 1 : last_code !== code)) begin
        n_err++;
        $display("FAIL rand_%0d: ok=%0d err=%0d code=%0d tick=%0d required code=%0d tick=%0d", k, ok_seen, err_seen, last_code, pulse_tick, code, et);
      end
    end
    rdy_rand = 1'b0;
    drain_wait();
    bad = 0;
    foreach (exp_q[i]) if (i >= got_q.size() || got_q[i] !== exp_q[i]) bad++;
    n_chk++;
    if (bad != 0 || got_q.size() != exp_q.size() || viol != 0) begin
      n_err++;
      $display("FAIL rand_drain: got %0d bytes (%0d wrong) viol=%0d required %0d bytes viol=0", got_q.size(), bad, viol, exp_q.size());
    end
    n_chk++;
    if (frame_cnt !== CNT_W'(exp_fcnt) || err_cnt !== CNT_W'(exp_ecnt)) begin
      n_err++;
      $display("FAIL rand_cnt: frame_cnt=%0d err_cnt=%0d required %0d %0d", frame_cnt, err_cnt, exp_fcnt, exp_ecnt);
    end
  endtask

  initial begin
    test_reset();
    test_good();
    test_backpressure();
    test_errors();
    test_overflow();
    test_boundary();
    test_back_to_back();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
